// File: rtl/pipe_ctrl.sv
// Pipeline control sequencer: hazard priority, per-stage write enables / bubbles, halt drain.
// Optional performance counters are compiled in when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       PCSrc,
  input  logic             load_use,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_id,
  output logic             pc_we,
  output logic             fd_we,
  output logic             de_we,
  output logic             em_we,
  output logic             mw_we,
  output logic             FD_NOP,
  output logic             DE_NOP,
  output logic             EM_NOP,
  output logic             MW_NOP,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] dcnt_q, dcnt_d;

  logic br;
  logic pc_we_c, fd_we_c, de_we_c, em_we_c, mw_we_c;
  logic fd_nop_c, de_nop_c, em_nop_c, mw_nop_c;
  logic stall_evt, flush_evt;

  // PCSrc 2'b10 and 2'b11 both select a redirected PC.
  assign br = PCSrc[1];

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      dcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    pc_we_c   = 1'b1;
    fd_we_c   = 1'b1;
    de_we_c   = 1'b1;
    em_we_c   = 1'b1;
    mw_we_c   = 1'b1;
    fd_nop_c  = 1'b0;
    de_nop_c  = 1'b0;
    em_nop_c  = 1'b0;
    mw_nop_c  = 1'b0;
    stall_evt = 1'b0;
    flush_evt = 1'b0;

    unique case (state_q)
      RUN: begin
        if (dmem_stall) begin
          // Freeze everything upstream of MEM; WB receives a bubble.
          pc_we_c   = 1'b0;
          fd_we_c   = 1'b0;
          de_we_c   = 1'b0;
          em_we_c   = 1'b0;
          mw_nop_c  = 1'b1;
          stall_evt = 1'b1;
        end else if (br) begin
          // A halt seen alongside a taken branch is wrong-path and is dropped.
          fd_nop_c  = 1'b1;
          de_nop_c  = 1'b1;
          flush_evt = 1'b1;
        end else if (load_use) begin
          pc_we_c   = 1'b0;
          fd_we_c   = 1'b0;
          de_nop_c  = 1'b1;
          stall_evt = 1'b1;
        end else if (imem_stall) begin
          pc_we_c   = 1'b0;
          fd_nop_c  = 1'b1;
          stall_evt = 1'b1;
        end else if (halt_id) begin
          pc_we_c  = 1'b0;
          fd_nop_c = 1'b1;
          state_d  = DRAIN;
          dcnt_d   = 2'd3;
        end
      end

      DRAIN: begin
        pc_we_c  = 1'b0;
        fd_nop_c = 1'b1;
        if (dmem_stall) begin
          fd_we_c   = 1'b0;
          de_we_c   = 1'b0;
          em_we_c   = 1'b0;
          mw_nop_c  = 1'b1;
          stall_evt = 1'b1;
        end else begin
          dcnt_d = dcnt_q - 2'd1;
          if (dcnt_q == 2'd1) begin
            state_d = HALTED;
          end
        end
      end

      HALTED: begin
        pc_we_c = 1'b0;
        fd_we_c = 1'b0;
        de_we_c = 1'b0;
        em_we_c = 1'b0;
        mw_we_c = 1'b0;
      end

      default: begin
        state_d = RUN;
        dcnt_d  = 2'd0;
      end
    endcase
  end

  // While reset is held the pipe is frozen and every register is told to bubble.
  assign pc_we  = rst & pc_we_c;
  assign fd_we  = rst & fd_we_c;
  assign de_we  = rst & de_we_c;
  assign em_we  = rst & em_we_c;
  assign mw_we  = rst & mw_we_c;
  assign FD_NOP = ~rst | fd_nop_c;
  assign DE_NOP = ~rst | de_nop_c;
  assign EM_NOP = ~rst | em_nop_c;
  assign MW_NOP = ~rst | mw_nop_c;
  assign halted = (state_q == HALTED);

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush_evt && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  logic unused_evt;
  assign unused_evt   = stall_evt ^ flush_evt;
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; expected enables pushed to a scoreboard at drive time.
// Counter checks follow PIPE_PERF_CNT_EN; the DUT uses CNT_W=2 to reach saturation quickly.
module tb_pipe_ctrl;

  localparam int CNT_W = 2;

  // {pc_we, fd_we, de_we, em_we, mw_we, FD_NOP, DE_NOP, EM_NOP, MW_NOP}
  localparam logic [8:0] E_RUN   = 9'b11111_0000;
  localparam logic [8:0] E_LU    = 9'b00111_0100;
  localparam logic [8:0] E_IM    = 9'b01111_1000;
  localparam logic [8:0] E_BR    = 9'b11111_1100;
  localparam logic [8:0] E_DM    = 9'b00001_0001;
  localparam logic [8:0] E_HACC  = 9'b01111_1000;
  localparam logic [8:0] E_DRAIN = 9'b01111_1000;
  localparam logic [8:0] E_DRDM  = 9'b00001_1001;
  localparam logic [8:0] E_HALT  = 9'b00000_0000;
  localparam logic [8:0] E_RST   = 9'b00000_1111;

  typedef struct packed {
    logic [8:0] en;
    logic       halted;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [1:0]       PCSrc;
  logic             load_use, imem_stall, dmem_stall, halt_id;
  logic             pc_we, fd_we, de_we, em_we, mw_we;
  logic             FD_NOP, DE_NOP, EM_NOP, MW_NOP;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .PCSrc        (PCSrc),
    .load_use     (load_use),
    .imem_stall   (imem_stall),
    .dmem_stall   (dmem_stall),
    .halt_id      (halt_id),
    .pc_we        (pc_we),
    .fd_we        (fd_we),
    .de_we        (de_we),
    .em_we        (em_we),
    .mw_we        (mw_we),
    .FD_NOP       (FD_NOP),
    .DE_NOP       (DE_NOP),
    .EM_NOP       (EM_NOP),
    .MW_NOP       (MW_NOP),
    .halted       (halted),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string name);
    exp_t e;
    e = sb.pop_front();
    check({name, ":en"}, 16'({pc_we, fd_we, de_we, em_we, mw_we,
                               FD_NOP, DE_NOP, EM_NOP, MW_NOP}), 16'(e.en));
    check({name, ":halted"}, 16'(halted), 16'(e.halted));
    check({name, ":stall_cycles"}, 16'(stall_cycles), 16'(exp_stall));
    check({name, ":flush_count"}, 16'(flush_count), 16'(exp_flush));
  endtask

  // One clock cycle: drive after the rising edge, sample at the falling edge.
  task automatic step(input string name, input logic [1:0] pcs, input logic lu, input logic im,
                      input logic dm, input logic hid, input logic [8:0] exp_en,
                      input logic exp_h, input bit st_inc, input bit fl_inc);
    @(posedge clk);
    #1;
    PCSrc      = pcs;
    load_use   = lu;
    imem_stall = im;
    dmem_stall = dm;
    halt_id    = hid;
    sb.push_back('{en: exp_en, halted: exp_h});
    @(negedge clk);
    compare(name);
`ifdef PIPE_PERF_CNT_EN
    if (st_inc && exp_stall < 3) exp_stall++;
    if (fl_inc && exp_flush < 3) exp_flush++;
`else
    if (st_inc || fl_inc) begin
      exp_stall = 0;
      exp_flush = 0;
    end
`endif
  endtask

  // Asynchronous reset asserted mid-cycle, checked while low, released at the falling edge.
  task automatic reset_check(input string name);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    PCSrc      = 2'b00;
    load_use   = 1'b0;
    imem_stall = 1'b0;
    dmem_stall = 1'b0;
    halt_id    = 1'b0;
    exp_stall  = 0;
    exp_flush  = 0;
    sb.push_back('{en: E_RST, halted: 1'b0});
    @(negedge clk);
    compare(name);
    rst = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    PCSrc      = 2'b00;
    load_use   = 1'b0;
    imem_stall = 1'b0;
    dmem_stall = 1'b0;
    halt_id    = 1'b0;

    reset_check("por");
    step("idle0",     2'b00, 0, 0, 0, 0, E_RUN, 0, 0, 0);
    step("pcsrc01",   2'b01, 0, 0, 0, 0, E_RUN, 0, 0, 0);
    step("load_use",  2'b00, 1, 0, 0, 0, E_LU,  0, 1, 0);
    step("lu_after",  2'b00, 0, 0, 0, 0, E_RUN, 0, 0, 0);
    step("imem",      2'b00, 0, 1, 0, 0, E_IM,  0, 1, 0);
    step("im_after",  2'b00, 0, 0, 0, 0, E_RUN, 0, 0, 0);

    // Branch overrides load-use and a wrong-path halt.
    reset_check("rst_br");
    step("br_lu_halt", 2'b10, 1, 0, 0, 1, E_BR,  0, 0, 1);
    step("br_after",   2'b00, 0, 0, 0, 0, E_RUN, 0, 0, 0);
    step("br_after2",  2'b00, 0, 0, 0, 0, E_RUN, 0, 0, 0);

    // Halt blocked by load-use or imem stall is retried, not taken.
    step("halt_lu",   2'b00, 1, 0, 0, 1, E_LU,  0, 1, 0);
    step("halt_im",   2'b00, 0, 1, 0, 1, E_IM,  0, 1, 0);
    step("no_drain",  2'b00, 0, 0, 0, 0, E_RUN, 0, 0, 0);

    // Stall-free halt: accepted in cycle 0, halted from cycle 4.
    reset_check("rst_h1");
    step("h1_c0",     2'b00, 0, 0, 0, 1, E_HACC,  0, 0, 0);
    step("h1_c1",     2'b11, 1, 1, 0, 1, E_DRAIN, 0, 0, 0);
    step("h1_c2",     2'b00, 0, 0, 0, 0, E_DRAIN, 0, 0, 0);
    step("h1_c3",     2'b00, 0, 0, 0, 0, E_DRAIN, 0, 0, 0);
    step("h1_c4",     2'b00, 0, 0, 0, 0, E_HALT,  1, 0, 0);
    step("h1_sticky", 2'b10, 1, 0, 1, 1, E_HALT,  1, 0, 0);

    // Same halt with a dmem stall in cycle 2: halted from cycle 5.
    reset_check("rst_h2");
    step("h2_c0",     2'b00, 0, 0, 0, 1, E_HACC,  0, 0, 0);
    step("h2_c1",     2'b00, 0, 0, 0, 0, E_DRAIN, 0, 0, 0);
    step("h2_c2",     2'b00, 0, 0, 1, 0, E_DRDM,  0, 1, 0);
    step("h2_c3",     2'b00, 0, 0, 0, 0, E_DRAIN, 0, 0, 0);
    step("h2_c4",     2'b00, 0, 0, 0, 0, E_DRAIN, 0, 0, 0);
    step("h2_c5",     2'b00, 0, 0, 0, 0, E_HALT,  1, 0, 0);

    // dmem stall holds a taken branch for three cycles; flush lands in cycle 4.
    reset_check("rst_dm");
    step("dm_c1",     2'b11, 0, 0, 1, 0, E_DM,  0, 1, 0);
    step("dm_c2",     2'b11, 0, 0, 1, 0, E_DM,  0, 1, 0);
    step("dm_c3",     2'b11, 0, 0, 1, 0, E_DM,  0, 1, 0);
    step("dm_c4",     2'b11, 0, 0, 0, 0, E_BR,  0, 0, 1);
    step("dm_c5",     2'b00, 0, 0, 0, 0, E_RUN, 0, 0, 0);

    // Reset in the middle of a drain abandons it.
    step("md_c0",     2'b00, 0, 0, 0, 1, E_HACC,  0, 0, 0);
    step("md_c1",     2'b00, 0, 0, 0, 0, E_DRAIN, 0, 0, 0);
    reset_check("md_rst");
    for (int i = 0; i < 5; i++) begin
      step($sformatf("md_run%0d", i), 2'b00, 0, 0, 0, 0, E_RUN, 0, 0, 0);
    end

    // Counter saturation at 2'b11.
    for (int i = 0; i < 5; i++) begin
      step($sformatf("sat_lu%0d", i), 2'b00, 1, 0, 0, 0, E_LU, 0, 1, 0);
    end
    for (int i = 0; i < 5; i++) begin
      step($sformatf("sat_br%0d", i), 2'b10, 0, 0, 0, 0, E_BR, 0, 0, 1);
    end
    step("sat_final", 2'b00, 0, 0, 0, 0, E_RUN, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
